// File: rtl/ntt_seq.sv
// Command sequencer for the NTT address/enable FSM: issues RADIX codes for the
// exact beat count, holds DONE codes while the write pipeline drains, checks done_flag.
module ntt_seq #(
    parameter int DRAIN_CYCLES = 14,
    parameter int R2_BEATS     = 32,
    parameter int R4_BEATS     = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [1:0] done_flag,
    output logic [2:0] conf,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    localparam logic [6:0]    R2_LAST    = 7'(R2_BEATS - 1);
    localparam logic [6:0]    R4_LAST    = 7'(R4_BEATS - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_R4   = 2'b10;
    localparam logic [1:0] MODE_MIX  = 2'b11;
    localparam logic [1:0] FLAG_NONE = 2'b00;
    localparam logic [1:0] FLAG_R2   = 2'b01;
    localparam logic [1:0] FLAG_R4   = 2'b10;

    // Encoding equals the conf command code, so conf is just the registered next state.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_R2       = 3'd1,
        S_R4       = 3'd2,
        S_R2_DRAIN = 3'd3,
        S_R4_DRAIN = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [6:0]    beat_cnt, beat_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic [1:0]    mode_q, mode_nxt;
    logic          err_nxt;
    logic          done_nxt;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_nxt = state;
        beat_nxt  = beat_cnt;
        drain_nxt = drain_cnt;
        mode_nxt  = mode_q;
        err_nxt   = err;
        done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                // The done cycle itself is not an accept window.
                if (start && mode != MODE_NONE && !done) begin
                    mode_nxt  = mode;
                    err_nxt   = 1'b0;
                    beat_nxt  = '0;
                    state_nxt = (mode == MODE_R4) ? S_R4 : S_R2;
                end
            end

            S_R2: begin
                if (done_flag != FLAG_NONE) err_nxt = 1'b1;
                if (beat_cnt == R2_LAST) begin
                    beat_nxt  = '0;
                    drain_nxt = '0;
                    state_nxt = S_R2_DRAIN;
                end else begin
                    beat_nxt = beat_cnt + 7'd1;
                end
            end

            S_R4: begin
                if (done_flag != FLAG_NONE) err_nxt = 1'b1;
                if (beat_cnt == R4_LAST) begin
                    beat_nxt  = '0;
                    drain_nxt = '0;
                    state_nxt = S_R4_DRAIN;
                end else begin
                    beat_nxt = beat_cnt + 7'd1;
                end
            end

            S_R2_DRAIN: begin
                // The address FSM sees conf one cycle late, so its last-beat flag lands here.
                if (drain_cnt == '0 && done_flag != FLAG_R2) err_nxt = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    drain_nxt = '0;
                    if (mode_q == MODE_MIX) begin
                        beat_nxt  = '0;
                        state_nxt = S_R4;
                    end else begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    drain_nxt = drain_cnt + DW'(1);
                end
            end

            S_R4_DRAIN: begin
                if (drain_cnt == '0 && done_flag != FLAG_R4) err_nxt = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    drain_nxt = '0;
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    drain_nxt = drain_cnt + DW'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
                beat_nxt  = '0;
                drain_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            mode_q    <= MODE_NONE;
            conf      <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_nxt;
            drain_cnt <= drain_nxt;
            mode_q    <= mode_nxt;
            conf      <= state_nxt;
            busy      <= (state_nxt != S_IDLE);
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ntt_seq.sv
// Self-checking bench for ntt_seq: a queue-of-expected-commands reference model
// checks every cycle under directed scenarios and randomized start/reset/flag traffic.
module tb_ntt_seq;

    localparam int D  = 14;
    localparam int NB2 = 32;
    localparam int NB4 = 96;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [1:0] done_flag;
    logic [2:0] conf;
    logic       busy;
    logic       done;
    logic       err;

    ntt_seq #(.DRAIN_CYCLES(D), .R2_BEATS(NB2), .R4_BEATS(NB4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .done_flag (done_flag),
        .conf      (conf),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One expected command cycle: conf code plus the done_flag it demands (if any).
    typedef struct packed {
        logic [2:0] code;
        logic       chk;
        logic [1:0] req;
    } item_t;

    item_t q[$];
    item_t cur;
    logic  m_done;
    logic  m_err;
    int    pos;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int e0       = 0;
    int n_done   = 0;
    int fault_idx = -1;
    logic [1:0] fault_val = 2'b00;
    bit rand_fault = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic void push_phase(input logic [2:0] beat_code, input int beats,
                                       input logic [2:0] drain_code, input logic [1:0] flag);
        item_t it;
        for (int i = 0; i < beats; i++) begin
            it = '{code: beat_code, chk: 1'b1, req: 2'b00};
            q.push_back(it);
        end
        for (int i = 0; i < D; i++) begin
            it = '{code: drain_code, chk: (i == 0), req: flag};
            q.push_back(it);
        end
    endfunction

    // Model of one clock edge using the inputs the DUT samples at that edge.
    task automatic model_update();
        logic new_done;
        if (rst) begin
            q.delete();
            cur    = '0;
            m_err  = 1'b0;
            m_done = 1'b0;
            pos    = 0;
            return;
        end
        if (cur.chk && done_flag != cur.req) m_err = 1'b1;
        new_done = 1'b0;
        if (q.size() > 0) begin
            cur = q.pop_front();
            pos++;
        end else if (cur.code != 3'd0) begin
            cur      = '0;
            new_done = 1'b1;
        end else if (start && mode != 2'b00 && !m_done) begin
            if (mode[0]) push_phase(3'd1, NB2, 3'd3, 2'b01);
            if (mode[1]) push_phase(3'd2, NB4, 3'd4, 2'b10);
            m_err = 1'b0;
            cur   = q.pop_front();
            pos   = 0;
        end
        m_done = new_done;
    endtask

    task automatic tick();
        logic [1:0] f;
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        check("conf", {29'd0, conf}, {29'd0, cur.code});
        check("busy", {31'd0, busy}, {31'd0, (cur.code != 3'd0)});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("err",  {31'd0, err},  {31'd0, m_err});
        if (done) n_done++;
        // Behave like a well-formed address FSM unless a fault is being injected.
        f = cur.chk ? cur.req : 2'($urandom);
        if (cur.code != 3'd0 && pos == fault_idx) f = fault_val;
        if (rand_fault && $urandom_range(0, 39) == 0) f = 2'($urandom);
        done_flag = f;
    endtask

    task automatic pulse_start(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        mode  = 2'($urandom);
    endtask

    task automatic start_tx(input logic [1:0] m);
        pulse_start(m);
        e0 = cyc;
    endtask

    task automatic wait_done(input int limit, output int lat);
        lat = -1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done) begin
                lat = cyc - e0;
                break;
            end
        end
    endtask

    int lat;
    int n0;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 2'b00;
        done_flag = 2'b00;
        cur       = '0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        pos       = 0;

        tick();
        tick();
        check("reset_conf", {29'd0, conf}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();

        // Radix-2 only
        n0 = n_done;
        start_tx(2'b01);
        check("r2_e0_conf", {29'd0, conf}, 32'd1);
        wait_done(300, lat);
        check("r2_latency", lat, 32'd46);
        check("r2_err", {31'd0, err}, 32'd0);
        // A start sampled in the done cycle is not accepted.
        pulse_start(2'b01);
        check("start_in_done_cycle", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        check("r2_one_done", n_done - n0, 32'd1);

        // Mixed
        n0 = n_done;
        start_tx(2'b11);
        wait_done(400, lat);
        check("mix_latency", lat, 32'd156);
        repeat (3) tick();
        check("mix_one_done", n_done - n0, 32'd1);
        check("mix_err", {31'd0, err}, 32'd0);

        // Radix-4 only
        start_tx(2'b10);
        wait_done(300, lat);
        check("r4_latency", lat, 32'd110);
        tick();

        // Missing last-beat flag in first R4_DRAIN cycle
        fault_idx = NB4;
        fault_val = 2'b00;
        start_tx(2'b10);
        wait_done(300, lat);
        fault_idx = -1;
        check("perr_latency", lat, 32'd110);
        check("perr_err_at_done", {31'd0, err}, 32'd1);
        tick();
        start_tx(2'b01);
        check("perr_cleared_by_start", {31'd0, err}, 32'd0);
        wait_done(300, lat);
        tick();

        // Early flag on R2 beat 10
        fault_idx = 10;
        fault_val = 2'b01;
        start_tx(2'b01);
        wait_done(300, lat);
        fault_idx = -1;
        check("early_latency", lat, 32'd46);
        check("early_err", {31'd0, err}, 32'd1);
        tick();

        // Ignored requests
        pulse_start(2'b00);
        check("mode00_ignored", {31'd0, busy}, 32'd0);
        start_tx(2'b01);
        repeat (20) tick();
        pulse_start(2'b10);
        repeat (15) tick();
        pulse_start(2'b11);
        wait_done(300, lat);
        check("busy_start_latency", lat, 32'd46);
        tick();

        // Reset mid-R4, with err already set so its clearing is visible
        fault_idx = 5;
        fault_val = 2'b01;
        start_tx(2'b10);
        repeat (49) tick();
        fault_idx = -1;
        check("pre_rst_err", {31'd0, err}, 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_conf", {29'd0, conf}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_err",  {31'd0, err},  32'd0);
        rst = 1'b0;
        tick();
        start_tx(2'b10);
        wait_done(300, lat);
        check("post_rst_r4_latency", lat, 32'd110);

        // Randomized traffic: sporadic starts, resets and corrupted flags
        rand_fault = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 599) == 0);
            start = ($urandom_range(0, 24) == 0);
            mode  = 2'($urandom);
            tick();
        end
        rst        = 1'b0;
        start      = 1'b0;
        rand_fault = 1'b0;
        repeat (200) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ntt_seq.md
# ntt_seq

Top-level sequencer that drives the `conf` command bus of the NTT address/enable FSM and supervises its `done_flag` return. It accepts a start request with a transform mode (radix-2 only, radix-4 only, or radix-2 followed by radix-4), then issues the RADIX code for the exact number of butterfly beats. It holds the matching DONE code while the 14-deep write pipeline drains, and reports completion or protocol error to the host. It sits between the host/CSR logic and the address FSM.

## Interface
- `DRAIN_CYCLES`, 14: cycles the DONE code is held after the last beat (write-enable pipeline depth); legal range ≥1.
- `R2_BEATS`, 32: radix-2 beats (i = 0..31).
- `R4_BEATS`, 96: radix-4 beats (3 stages × 32; p = 2,1,0).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle request, sampled only in IDLE.
- `mode`  in  2  sampled with `start`: 01 radix-2, 10 radix-4, 11 radix-2 then radix-4, 00 ignored.
- `done_flag`  in  2  from address FSM: 01 last radix-2 beat, 10 last radix-4 beat.
- `conf`  out  3  registered command: 0 IDLE, 1 RADIX2, 2 RADIX4, 3 DONE_RADIX2, 4 DONE_RADIX4.
- `busy`  out  1  registered; high while a transform is in progress.
- `done`  out  1  registered one-cycle completion pulse.
- `err`  out  1  sticky protocol error.

## Operation
- States: IDLE (conf=0), R2 (conf=1), R2_DRAIN (conf=3), R4 (conf=2), R4_DRAIN (conf=4).
- IDLE with start=1 and mode≠00 gives the next state R2 (mode 01/11) or R4 (mode 10). It latches `mode`, clears `err` and sets `busy`. start with mode=00, or start outside IDLE, is ignored.
- R2/R4 use a 7-bit beat counter that starts at 0. After beat R2_BEATS−1 or R4_BEATS−1, the next state is the matching DRAIN state and the counter clears.
- DRAIN uses a drain counter of width clog2(DRAIN_CYCLES+1). After DRAIN_CYCLES cycles:
  - R2_DRAIN with latched mode 11 goes to R4.
  - Any other DRAIN goes to IDLE, with `done`=1 for that first IDLE cycle and `busy`=0.
- A DONE code always separates two RADIX codes, so the FSM's counters re-initialise (p reloads to 2 on entry to RADIX4).
- done_flag checking, which accounts for the FSM's one-cycle conf register:
  - First cycle of R2_DRAIN: done_flag must be 01.
  - First cycle of R4_DRAIN: done_flag must be 10.
  - Every R2/R4 beat cycle: done_flag must be 00.
  - Any violation sets `err`. It stays set until the next accepted start or rst, and sequencing continues unaffected.
- rst at any time, including mid-transform: the next cycle is IDLE with conf=0, busy=0, done=0, err=0, all counters 0.

## Timing
- Reset values: conf=0, busy=0, done=0, err=0.
- E0 is the edge that samples start=1. conf and busy update at E0, so there is zero added latency.
- Radix-2 only (D=DRAIN_CYCLES):
  - conf=1 for E0..E0+31.
  - conf=3 for E0+32..E0+31+D.
  - conf=0, done=1, busy=0 at E0+32+D.
- Radix-4 only:
  - conf=2 for E0..E0+95.
  - conf=4 for E0+96..E0+95+D.
  - done at E0+96+D.
- Mixed:
  - conf=1 for E0..+31.
  - conf=3 for +32..+31+D.
  - conf=2 for +32+D..+127+D.
  - conf=4 for +128+D..+127+2D.
  - done at +128+2D.
- With D=14, done arrives at +46 (radix-2 only), +110 (radix-4 only) or +156 (mixed).
- start is re-accepted in the cycle after done, not in the done cycle itself.

## Test plan
- Reset mid-R4 (rst at E0+50 of radix-4): the next cycle has conf=0, busy=0, err=0. A new start then begins a fresh 96-beat sequence.
- Radix-2 only with a behavioural FSM model: conf=1 for 32 cycles then 3 for 14. done pulses at E0+46 and err=0.
- Mixed mode: the conf sequence is 1×32, 3×14, 2×96, 4×14, then done at E0+156. Exactly one done pulse and err=0.
- Protocol error: force done_flag=00 in the first R4_DRAIN cycle → err=1 stays high through done. The next start clears it.
- Early flag: drive done_flag=01 on R2 beat 10 → err=1. Sequence timing is unchanged (done still at E0+46).
- Ignored requests: start with mode=00 in IDLE → busy stays 0. start pulses during busy → no restart and timing is unchanged.
